// File: rtl/nand_filt_nin_if.sv
// Logic-side bundle of the filtered N-input gate: control, data inputs and
// the filtered result with its event pulses.
interface nand_filt_nin_if #(
    parameter int N = 2
);
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] i;
    logic         o;
    logic         chg;
    logic         rej;

    modport master (output en, mode, i, input  o, chg, rej);
    modport slave  (input  en, mode, i, output o, chg, rej);
endinterface

// File: rtl/nand_filt_nin.sv
// N-input NAND/AND/NOR/OR gate with optional input synchroniser and a
// consecutive-cycle glitch filter on the registered output.
//
// state  | meaning
// STABLE | o agrees with the gate result, counter idle
// PEND   | gate result disagrees with o, counting toward FILT
module nand_filt_nin #(
    parameter int N    = 2,
    parameter int SYNC = 2,
    parameter int FILT = 4,
    parameter bit INIT = 1'b1
) (
    input logic          CELCLK,
    input logic          CELRST,
    input logic          CELV,
    input logic          CELG,
    input logic          SUB,
    nand_filt_nin_if.slave bus
);
    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic {STABLE = 1'b0, PEND = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          o_q, o_d;
    logic          chg_q, chg_d;
    logic          rej_q, rej_d;
    logic [N-1:0]  in_s;
    logic          raw;

    // Supply/substrate pins exist only for netlist compatibility.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    generate
        if (SYNC == 0) begin : g_nosync
            assign in_s = bus.i;
        end else begin : g_sync
            logic [N-1:0] sync_q [SYNC];
            always_ff @(posedge CELCLK or posedge CELRST) begin
                if (CELRST) begin
                    for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= bus.i;
                    for (int k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign in_s = sync_q[SYNC-1];
        end
    endgenerate

    always_comb begin
        raw = 1'b0;
        case (bus.mode)
            2'b00: raw = ~&in_s;
            2'b01: raw =  &in_s;
            2'b10: raw = ~|in_s;
            2'b11: raw =  |in_s;
            default: raw = 1'b0;
        endcase
    end

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            o_q     <= INIT;
            chg_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            chg_q   <= chg_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        chg_d   = 1'b0;
        rej_d   = 1'b0;
        // Disable wins over any transition and silently drops a pending change.
        if (!bus.en) begin
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    cnt_d = '0;
                    if (raw != o_q) begin
                        if (FILT == 1) begin
                            o_d   = raw;
                            chg_d = 1'b1;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = PEND;
                        end
                    end
                end
                PEND: begin
                    if (raw == o_q) begin
                        cnt_d   = '0;
                        rej_d   = 1'b1;
                        state_d = STABLE;
                    end else if (cnt_q == CNT_LAST) begin
                        o_d     = raw;
                        chg_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = STABLE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.o   = o_q;
    assign bus.chg = chg_q;
    assign bus.rej = rej_q;
endmodule
